// File: rtl/i2c_mem_arbiter.sv
// i2c_mem_arbiter: round-robin share of one I2C memory transaction port among NREQ requesters.
// Latency: command registered on the edge ending mem_done; response at the next mem_done edge.
// Backpressure: requesters hold req until granted; idle slots are filled with parked reads.
// Optional watchdog: define I2C_ARB_TIMEOUT_EN to abort a BUSY transaction after TIMEOUT cycles.
module i2c_mem_arbiter #(
    parameter int          NREQ      = 4,
    parameter logic [6:0]  PARK_ADDR = 7'h7F,
    parameter int          TIMEOUT   = 1023
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         req_wr,
    input  logic [NREQ*7-1:0]       req_addr,
    input  logic [NREQ*8-1:0]       req_din,
    output logic [NREQ-1:0]         gnt,
    output logic                    rsp_valid,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [7:0]              rsp_data,
    output logic                    rsp_err,
    output logic                    mem_wr,
    output logic [6:0]              mem_addr,
    output logic [7:0]              mem_din,
    input  logic [7:0]              mem_datard,
    input  logic                    mem_done
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {SYNC, FILL, BUSY} state_t;

    state_t        state;
    logic [IW-1:0] last_winner;
    logic [IW-1:0] owner;
    logic [IW-1:0] winner;
    logic          found;
    int            idx;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt;
    logic          err_q;
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    // Round-robin search starting one past the previous winner.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_winner) + k) % NREQ;
            if (!found && req[idx[IW-1:0]]) begin
                found  = 1'b1;
                winner = idx[IW-1:0];
            end
        end
    end

    // Transaction FSM: complete/arbitrate at each mem_done, park outputs when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SYNC;
            last_winner <= IW'(NREQ - 1);
            owner       <= '0;
            gnt         <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_data    <= 8'h00;
            mem_wr      <= 1'b0;
            mem_addr    <= PARK_ADDR;
            mem_din     <= 8'h00;
`ifdef I2C_ARB_TIMEOUT_EN
            tcnt        <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
            if (mem_done) begin
                // Finish the in-flight granted transaction; read data exists only this cycle.
                if (state == BUSY) begin
                    rsp_valid <= 1'b1;
                    rsp_id    <= owner;
                    rsp_data  <= mem_wr ? 8'h00 : mem_datard;
                end
                gnt <= '0;
                if (found) begin
                    mem_wr      <= req_wr[winner];
                    mem_addr    <= req_addr[7*winner +: 7];
                    mem_din     <= req_din[8*winner +: 8];
                    gnt[winner] <= 1'b1;
                    owner       <= winner;
                    last_winner <= winner;
                    state       <= BUSY;
                end else begin
                    mem_wr   <= 1'b0;
                    mem_addr <= PARK_ADDR;
                    mem_din  <= 8'h00;
                    state    <= FILL;
                end
`ifdef I2C_ARB_TIMEOUT_EN
                tcnt <= '0;
`endif
            end
`ifdef I2C_ARB_TIMEOUT_EN
            else if (state == BUSY) begin
                // Watchdog: memory stopped completing, abort and wait for realignment.
                if (tcnt == TW'(TIMEOUT - 1)) begin
                    rsp_valid <= 1'b1;
                    err_q     <= 1'b1;
                    rsp_id    <= owner;
                    rsp_data  <= 8'h00;
                    gnt       <= '0;
                    mem_wr    <= 1'b0;
                    mem_addr  <= PARK_ADDR;
                    mem_din   <= 8'h00;
                    state     <= SYNC;
                    tcnt      <= '0;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_i2c_mem_arbiter.sv
// Directed bench for i2c_mem_arbiter with a free-running behavioural I2C memory.
// Memory: done every P cycles, command sampled two edges after done, read data valid only in done cycle.
// Expected values are hand-derived from the arbitration order and memory contents.
module tb_i2c_mem_arbiter;

    localparam int NREQ = 4;
    localparam int P    = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, req_wr;
    logic [27:0] req_addr;
    logic [31:0] req_din;
    logic [3:0]  gnt;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_data;
    logic        rsp_err;
    logic        mem_wr;
    logic [6:0]  mem_addr;
    logic [7:0]  mem_din;
    logic [7:0]  mem_datard;
    logic        mem_done;

    int passes = 0;
    int total  = 0;

    i2c_mem_arbiter #(.NREQ(NREQ), .PARK_ADDR(7'h7F), .TIMEOUT(50)) dut (
        .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_addr(req_addr),
        .req_din(req_din), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_datard(mem_datard), .mem_done(mem_done)
    );

    always #5 clk = ~clk;

    // Behavioural memory
    bit [7:0]    mem [128];
    int unsigned mcnt = 0;
    bit          done_en = 1'b1;
    bit          lat_wr;
    bit [6:0]    lat_addr;
    bit [7:0]    lat_din;

    assign mem_done   = done_en && (mcnt == P - 1);
    assign mem_datard = (mem_done && !lat_wr) ? mem[lat_addr] : 8'h00;

    always @(posedge clk) begin
        mcnt <= (mcnt == P - 1) ? 0 : mcnt + 1;
        if (mcnt == 1) begin
            lat_wr   <= mem_wr;
            lat_addr <= mem_addr;
            lat_din  <= mem_din;
        end
        if (mem_done && lat_wr) mem[lat_addr] <= lat_din;
    end

    // Monitor: responses, grant changes, one-hot and idle tracking
    int         cyc = 0;
    int         onehot_err = 0;
    int         idle_cnt = 0;
    bit         watch = 1'b0;
    logic [3:0] prev_gnt = '0;
    int rq_id[$], rq_data[$], rq_err[$], rq_cyc[$];
    int gq_id[$], gq_cyc[$];

    always @(negedge clk) begin
        cyc++;
        if ($countones(gnt) > 1) onehot_err++;
        if (watch && gnt == 4'b0000) idle_cnt++;
        if (rsp_valid === 1'b1) begin
            rq_id.push_back(int'(rsp_id));
            rq_data.push_back(int'(rsp_data));
            rq_err.push_back(int'(rsp_err));
            rq_cyc.push_back(cyc);
        end
        if (gnt != prev_gnt && gnt != 4'b0000) begin
            for (int i = 0; i < NREQ; i++) begin
                if (gnt[i]) begin
                    gq_id.push_back(i);
                    gq_cyc.push_back(cyc);
                end
            end
        end
        prev_gnt = gnt;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tfail(input string tag);
        total++;
        $error("FAIL %s: observed timeout expected event", tag);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic set_cmd(input int i, input bit w, input logic [6:0] a, input logic [7:0] d);
        req_wr[i]         = w;
        req_addr[7*i +: 7] = a;
        req_din[8*i +: 8]  = d;
        req[i]            = 1'b1;
    endtask

    task automatic wait_gnt(input int i);
        for (int k = 0; k < 100 && gnt[i] !== 1'b1; k++) cycles(1);
        if (gnt[i] !== 1'b1) tfail("grant_wait");
        req[i] = 1'b0;
    endtask

    task automatic issue(input int i, input bit w, input logic [6:0] a, input logic [7:0] d);
        set_cmd(i, w, a, d);
        wait_gnt(i);
    endtask

    task automatic wait_rsp(output int id, output int data, output int err, output int rc);
        for (int k = 0; k < 200 && rq_id.size() == 0; k++) cycles(1);
        if (rq_id.size() == 0) begin
            tfail("rsp_wait");
            id = -1; data = -1; err = -1; rc = -1;
        end else begin
            id = rq_id.pop_front(); data = rq_data.pop_front();
            err = rq_err.pop_front(); rc = rq_cyc.pop_front();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_gnt"},       32'(gnt),       32'h0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        chk({tag, "_rsp_err"},   32'(rsp_err),   32'h0);
        chk({tag, "_mem_wr"},    32'(mem_wr),    32'h0);
        chk({tag, "_mem_addr"},  32'(mem_addr),  32'h7F);
        chk({tag, "_mem_din"},   32'(mem_din),   32'h0);
    endtask

    initial begin
        int id, data, err, rc, gc;
        int exp_order[5] = '{0, 1, 2, 3, 0};

        rst = 1'b1; req = '0; req_wr = '0; req_addr = '0; req_din = '0;
        cycles(3);
        chk_reset_vals("reset");
        chk("reset_rsp_id",   32'(rsp_id),   32'h0);
        chk("reset_rsp_data", 32'(rsp_data), 32'h0);
        rst = 1'b0;

        // Idle: three filler transactions with no response
        cycles(3 * P + 4);
        chk("fill_no_rsp",  32'(rq_id.size()), 32'h0);
        chk("fill_addr",    32'(mem_addr),     32'h7F);
        chk("fill_wr",      32'(mem_wr),       32'h0);
        chk("fill_gnt",     32'(gnt),          32'h0);

        // Requester 0: write then read back
        issue(0, 1'b1, 7'h12, 8'hA5);
        wait_rsp(id, data, err, rc);
        chk("wr0_id", 32'(id), 32'h0);
        chk("wr0_data", 32'(data), 32'h0);
        chk("wr0_err", 32'(err), 32'h0);
        issue(0, 1'b0, 7'h12, 8'h00);
        wait_rsp(id, data, err, rc);
        chk("rd0_id", 32'(id), 32'h0);
        chk("rd0_data", 32'(data), 32'hA5);

        // All four requesters held: round-robin from index 0
        do_reset();
        gq_id.delete(); gq_cyc.delete();
        for (int i = 0; i < NREQ; i++) set_cmd(i, 1'b0, 7'h12, 8'h00);
        for (int k = 0; k < 200 && gq_id.size() < 5; k++) begin
            cycles(1);
            if (gq_id.size() >= 1) watch = 1'b1;
        end
        watch = 1'b0;
        req = '0;
        if (gq_id.size() < 5) tfail("rr_grants");
        for (int k = 0; k < 5; k++) begin
            if (k < gq_id.size()) chk($sformatf("rr_gnt%0d", k), 32'(gq_id[k]), 32'(exp_order[k]));
        end
        for (int k = 0; k < 5; k++) begin
            wait_rsp(id, data, err, rc);
            chk($sformatf("rr_rsp_id%0d", k), 32'(id), 32'(exp_order[k]));
            chk($sformatf("rr_rsp_data%0d", k), 32'(data), 32'hA5);
        end
        chk("rr_onehot", 32'(onehot_err), 32'h0);
        chk("rr_no_idle", 32'(idle_cnt), 32'h0);

        // Same decision point: requester 1 reads before requester 2 writes
        do_reset();
        set_cmd(1, 1'b0, 7'h05, 8'h00);
        set_cmd(2, 1'b1, 7'h05, 8'h3C);
        wait_gnt(1);
        wait_gnt(2);
        wait_rsp(id, data, err, rc);
        chk("race_first_id", 32'(id), 32'h1);
        chk("race_first_data", 32'(data), 32'h00);
        wait_rsp(id, data, err, rc);
        chk("race_second_id", 32'(id), 32'h2);
        issue(2, 1'b0, 7'h05, 8'h00);
        wait_rsp(id, data, err, rc);
        chk("race_readback_id", 32'(id), 32'h2);
        chk("race_readback_data", 32'(data), 32'h3C);

        // Reset in the middle of a granted transaction
        issue(3, 1'b0, 7'h12, 8'h00);
        cycles(2);
        rst = 1'b1;
        cycles(1);
        chk_reset_vals("midrst");
        rst = 1'b0;
        cycles(3 * P);
        chk("midrst_no_stale", 32'(rq_id.size()), 32'h0);
        issue(3, 1'b0, 7'h12, 8'h00);
        wait_rsp(id, data, err, rc);
        chk("midrst_recover_id", 32'(id), 32'h3);
        chk("midrst_recover_data", 32'(data), 32'hA5);

`ifdef I2C_ARB_TIMEOUT_EN
        // Watchdog: memory stops completing right after the grant
        gq_id.delete(); gq_cyc.delete();
        issue(0, 1'b0, 7'h12, 8'h00);
        done_en = 1'b0;
        gc = (gq_cyc.size() > 0) ? gq_cyc[gq_cyc.size() - 1] : 0;
        wait_rsp(id, data, err, rc);
        chk("to_err", 32'(err), 32'h1);
        chk("to_id", 32'(id), 32'h0);
        chk("to_data", 32'(data), 32'h0);
        chk("to_latency", 32'(rc - gc), 32'd50);
        chk("to_gnt", 32'(gnt), 32'h0);
        chk("to_park", 32'(mem_addr), 32'h7F);
        done_en = 1'b1;
        issue(0, 1'b1, 7'h20, 8'h5A);
        wait_rsp(id, data, err, rc);
        chk("to_recover_err", 32'(err), 32'h0);
        chk("to_recover_id", 32'(id), 32'h0);
`else
        gc = 0;
`endif

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
